// File: rtl/vga_circle_ctrl_pkg.sv
// vga_circle_ctrl_pkg: shared limits, encodings and types for the circle parameter controller
package vga_circle_ctrl_pkg;

    localparam logic [9:0] X_MAX = 10'd639;
    localparam logic [9:0] Y_MAX = 10'd479;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'b00,
        MODE_BREATHE = 2'b01,
        MODE_DRIFT   = 2'b10,
        MODE_FREEZE  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ADDR_CX   = 2'd0,
        ADDR_CY   = 2'd1,
        ADDR_RAD  = 2'd2,
        ADDR_BAND = 2'd3
    } addr_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ANIM,
        ST_COMMIT,
        ST_WAIT
    } state_e;

    typedef struct packed {
        logic [9:0] cx;
        logic [9:0] cy;
        logic [9:0] radius;
        logic [9:0] band;
    } circle_t;

    function automatic logic [9:0] lim(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

endpackage

// File: rtl/vga_circle_ctrl_if.sv
// vga_circle_ctrl_if: host write port (valid/ready handshake) into the shadow parameter set
interface vga_circle_ctrl_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [9:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/vga_circle_ctrl_circle_anim.sv
// circle_anim: frame divider, breathe direction and next-value logic for the animated fields
module circle_anim
    import vga_circle_ctrl_pkg::*;
#(
    parameter int RAD_MIN     = 16,
    parameter int RAD_MAX     = 200,
    parameter int STEP_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_adv,
    input  mode_e      i_sel,
    input  logic       i_rad_lock,
    input  logic       i_cx_lock,
    input  logic [9:0] i_radius,
    input  logic [9:0] i_cx,
    output logic       o_rad_we,
    output logic [9:0] o_radius,
    output logic       o_cx_we,
    output logic [9:0] o_cx
);

    localparam int         DW   = $clog2(STEP_FRAMES + 1);
    localparam logic [DW-1:0] LAST = DW'(STEP_FRAMES - 1);
    localparam logic [9:0] RMIN = 10'(RAD_MIN);
    localparam logic [9:0] RMAX = 10'(RAD_MAX);

    logic [DW-1:0] div;
    logic          dir_up;
    logic          step;
    logic          dir_eff;

    // step decision and candidate values; a radius sitting on a limit turns around in the same step
    always_comb begin
        step     = (div == LAST);
        dir_eff  = (i_radius >= RMAX) ? 1'b0 : (i_radius <= RMIN) ? 1'b1 : dir_up;
        o_rad_we = i_adv & step & (i_sel == MODE_BREATHE) & ~i_rad_lock;
        o_cx_we  = i_adv & step & (i_sel == MODE_DRIFT) & ~i_cx_lock;
        o_radius = dir_eff ? i_radius + 10'd1 : i_radius - 10'd1;
        o_cx     = (i_cx >= X_MAX) ? 10'd0 : i_cx + 10'd1;
    end

    // divider advances once per ANIM in every mode; direction only changes when the radius moves
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div    <= '0;
            dir_up <= 1'b1;
        end else if (i_adv) begin
            div <= step ? '0 : div + 1'b1;
            if (o_rad_we) dir_up <= dir_eff;
        end
    end

endmodule

// File: rtl/vga_circle_ctrl.sv
// vga_circle_ctrl: shadow/active circle parameters, host port, animator and vblank-synchronous commit
module vga_circle_ctrl
    import vga_circle_ctrl_pkg::*;
#(
    parameter int RAD_MIN     = 16,
    parameter int RAD_MAX     = 200,
    parameter int RAD_INIT    = 100,
    parameter int CX_INIT     = 320,
    parameter int CY_INIT     = 240,
    parameter int BAND_INIT   = 100,
    parameter int STEP_FRAMES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_vblank,
    input  logic [1:0]          i_sel,
    vga_circle_ctrl_if.slave    wr,
    output logic [9:0]          o_cx,
    output logic [9:0]          o_cy,
    output logic [9:0]          o_radius,
    output logic [9:0]          o_band,
    output logic                o_upd,
    output logic [11:0]         o_frame_cnt
);

    localparam circle_t INIT = '{cx: 10'(CX_INIT), cy: 10'(CY_INIT), radius: 10'(RAD_INIT), band: 10'(BAND_INIT)};

    state_e     state, state_d;
    circle_t    shadow, shadow_d, active;
    logic [3:0] dirty, dirty_d;
    logic       vb_q;
    logic       ready_q;
    logic       fs;
    logic       acc;
    logic       commit;
    mode_e      sel;
    logic       rad_we, cx_we;
    logic [9:0] anim_radius, anim_cx;

    assign sel         = mode_e'(i_sel);
    assign fs          = i_vblank & ~vb_q;
    assign acc         = wr.wr_valid & ready_q;
    assign commit      = (state == ST_COMMIT) & (sel != MODE_FREEZE);
    assign wr.wr_ready = ready_q;
    assign o_cx        = active.cx;
    assign o_cy        = active.cy;
    assign o_radius    = active.radius;
    assign o_band      = active.band;

    circle_anim #(
        .RAD_MIN     (RAD_MIN),
        .RAD_MAX     (RAD_MAX),
        .STEP_FRAMES (STEP_FRAMES)
    ) u_anim (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_adv      (state == ST_ANIM),
        .i_sel      (sel),
        .i_rad_lock (dirty[ADDR_RAD]),
        .i_cx_lock  (dirty[ADDR_CX]),
        .i_radius   (shadow.radius),
        .i_cx       (shadow.cx),
        .o_rad_we   (rad_we),
        .o_radius   (anim_radius),
        .o_cx_we    (cx_we),
        .o_cx       (anim_cx)
    );

    // frame sequencer: one ANIM and one COMMIT per vblank rising edge, then wait for vblank to drop
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   state_d = fs ? ST_ANIM : ST_IDLE;
            ST_ANIM:   state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_WAIT;
            ST_WAIT:   state_d = i_vblank ? ST_WAIT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // shadow next value: host writes (IDLE/WAIT) and animator updates (ANIM) never coincide
    always_comb begin
        shadow_d = shadow;
        dirty_d  = commit ? 4'b0000 : dirty;
        if (acc) begin
            dirty_d[wr.wr_addr] = 1'b1;
            case (addr_e'(wr.wr_addr))
                ADDR_CX:   shadow_d.cx     = lim(wr.wr_data, 10'd0, X_MAX);
                ADDR_CY:   shadow_d.cy     = lim(wr.wr_data, 10'd0, Y_MAX);
                ADDR_RAD:  shadow_d.radius = lim(wr.wr_data, 10'(RAD_MIN), 10'(RAD_MAX));
                default:   shadow_d.band   = wr.wr_data;
            endcase
        end
        if (rad_we) shadow_d.radius = anim_radius;
        if (cx_we) shadow_d.cx = anim_cx;
    end

    // state, handshake and parameter registers; active only moves on a non-frozen commit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            vb_q        <= 1'b0;
            ready_q     <= 1'b1;
            shadow      <= INIT;
            active      <= INIT;
            dirty       <= 4'b0000;
            o_upd       <= 1'b0;
            o_frame_cnt <= 12'd0;
        end else begin
            state       <= state_d;
            vb_q        <= i_vblank;
            ready_q     <= (state_d == ST_IDLE) | (state_d == ST_WAIT);
            shadow      <= shadow_d;
            dirty       <= dirty_d;
            o_upd       <= commit;
            o_frame_cnt <= o_frame_cnt + {11'd0, state == ST_COMMIT};
            if (commit) active <= shadow;
        end
    end

endmodule

// File: tb/tb_vga_circle_ctrl.sv
// tb_vga_circle_ctrl: scoreboard bench for the circle parameter controller
module tb_vga_circle_ctrl;
    import vga_circle_ctrl_pkg::*;

    localparam int SF = 1;

    typedef struct {
        logic [9:0]  cx;
        logic [9:0]  cy;
        logic [9:0]  r;
        logic [9:0]  b;
        logic        upd;
        logic [11:0] cnt;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_vblank = 1'b0;
    logic [1:0]  i_sel = 2'b00;
    logic [9:0]  o_cx, o_cy, o_radius, o_band;
    logic        o_upd;
    logic [11:0] o_frame_cnt;

    vga_circle_ctrl_if bus();

    vga_circle_ctrl #(.STEP_FRAMES(SF)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_vblank    (i_vblank),
        .i_sel       (i_sel),
        .wr          (bus),
        .o_cx        (o_cx),
        .o_cy        (o_cy),
        .o_radius    (o_radius),
        .o_band      (o_band),
        .o_upd       (o_upd),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    logic [9:0]  m_cx = 10'd320, m_cy = 10'd240, m_r = 10'd100, m_b = 10'd100;
    logic [9:0]  a_cx = 10'd320, a_cy = 10'd240, a_r = 10'd100, a_b = 10'd100;
    logic [3:0]  m_dirty = 4'b0;
    logic        m_up = 1'b1;
    int          m_div = 0;
    logic [11:0] m_cnt = 12'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cx = 10'd320; m_cy = 10'd240; m_r = 10'd100; m_b = 10'd100;
        a_cx = m_cx; a_cy = m_cy; a_r = m_r; a_b = m_b;
        m_dirty = 4'b0; m_up = 1'b1; m_div = 0; m_cnt = 12'd0;
        q.delete();
    endtask

    task automatic model_write(input logic [1:0] a, input logic [9:0] d);
        case (a)
            2'd0: m_cx = (d > 10'd639) ? 10'd639 : d;
            2'd1: m_cy = (d > 10'd479) ? 10'd479 : d;
            2'd2: m_r = (d < 10'd16) ? 10'd16 : (d > 10'd200) ? 10'd200 : d;
            default: m_b = d;
        endcase
        m_dirty[a] = 1'b1;
    endtask

    task automatic model_frame();
        exp_t e;
        bit step;
        step = (m_div == SF - 1);
        m_div = step ? 0 : m_div + 1;
        if (step && i_sel == 2'b01 && !m_dirty[2]) begin
            if (m_r == 10'd200) m_up = 1'b0;
            else if (m_r == 10'd16) m_up = 1'b1;
            m_r = m_up ? m_r + 10'd1 : m_r - 10'd1;
        end
        if (step && i_sel == 2'b10 && !m_dirty[0])
            m_cx = (m_cx == 10'd639) ? 10'd0 : m_cx + 10'd1;
        if (i_sel != 2'b11) begin
            a_cx = m_cx; a_cy = m_cy; a_r = m_r; a_b = m_b;
            m_dirty = 4'b0;
        end
        m_cnt = m_cnt + 12'd1;
        e = '{cx: a_cx, cy: a_cy, r: a_r, b: a_b, upd: (i_sel != 2'b11), cnt: m_cnt};
        q.push_back(e);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [9:0] d);
        int n = 0;
        @(negedge i_clk);
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        while (!bus.wr_ready && n < 20) begin
            n++;
            @(negedge i_clk);
        end
        if (n >= 20) chk("wr_timeout", n, 0);
        @(posedge i_clk);
        #1 bus.wr_valid = 1'b0;
        model_write(a, d);
    endtask

    task automatic do_frame(input int hi);
        @(negedge i_clk);
        i_vblank = 1'b1;
        model_frame();
        repeat (hi) @(negedge i_clk);
        i_vblank = 1'b0;
        repeat (5) @(negedge i_clk);
    endtask

    logic [11:0] last_cnt = 12'd0;
    logic        last_upd = 1'b0;
    exp_t        mon_e;

    // commit monitor: every frame-count step pops one expected frame
    always @(negedge i_clk) begin
        if (i_rst) begin
            last_cnt = 12'd0;
            last_upd = 1'b0;
        end else begin
            if (o_frame_cnt != last_cnt) begin
                if (q.size() == 0) chk("unexpected_commit", 32'(o_frame_cnt), 32'(last_cnt));
                else begin
                    mon_e = q.pop_front();
                    chk("cx", 32'(o_cx), 32'(mon_e.cx));
                    chk("cy", 32'(o_cy), 32'(mon_e.cy));
                    chk("radius", 32'(o_radius), 32'(mon_e.r));
                    chk("band", 32'(o_band), 32'(mon_e.b));
                    chk("upd", 32'(o_upd), 32'(mon_e.upd));
                    chk("frame_cnt", 32'(o_frame_cnt), 32'(mon_e.cnt));
                end
                last_cnt = o_frame_cnt;
            end else if (last_upd) chk("upd_width", 32'(o_upd), 0);
            last_upd = o_upd;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.wr_valid = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 10'd0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_cx", 32'(o_cx), 320);
        chk("rst_cy", 32'(o_cy), 240);
        chk("rst_radius", 32'(o_radius), 100);
        chk("rst_band", 32'(o_band), 100);
        chk("rst_upd", 32'(o_upd), 0);
        chk("rst_cnt", 32'(o_frame_cnt), 0);
        chk("rst_ready", 32'(bus.wr_ready), 1);

        @(negedge i_clk);
        i_vblank = 1'b1;
        model_frame();
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_upd && n < 10);
        chk("upd_latency", n, 3);
        @(negedge i_clk);
        i_vblank = 1'b0;
        repeat (5) @(negedge i_clk);

        i_sel = 2'b00;
        host_write(2'd2, 10'd5);
        host_write(2'd1, 10'd900);
        do_frame(4);

        i_sel = 2'b01;
        host_write(2'd2, 10'd198);
        repeat (5) do_frame(4);

        i_sel = 2'b10;
        host_write(2'd0, 10'd639);
        do_frame(2);
        do_frame(1);
        do_frame(4);

        i_sel = 2'b00;
        @(negedge i_clk);
        i_vblank = 1'b1;
        model_frame();
        @(negedge i_clk);
        bus.wr_valid = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 10'd123;
        n = 0;
        while (!bus.wr_ready && n < 10) begin
            n++;
            @(negedge i_clk);
        end
        chk("ready_low_cycles", n, 2);
        @(posedge i_clk);
        #1 bus.wr_valid = 1'b0;
        model_write(2'd1, 10'd123);
        @(negedge i_clk);
        i_vblank = 1'b0;
        repeat (5) @(negedge i_clk);
        do_frame(4);

        @(negedge i_clk);
        i_vblank = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 10'd77;
        @(posedge i_clk);
        #1 bus.wr_valid = 1'b0;
        model_write(2'd3, 10'd77);
        model_frame();
        repeat (4) @(negedge i_clk);
        i_vblank = 1'b0;
        repeat (5) @(negedge i_clk);

        i_sel = 2'b11;
        host_write(2'd0, 10'd50);
        repeat (3) do_frame(4);
        i_sel = 2'b00;
        do_frame(4);

        host_write(2'd0, 10'd77);
        @(negedge i_clk);
        i_vblank = 1'b1;
        repeat (2) @(negedge i_clk);
        #2 i_rst = 1'b1;
        model_reset();
        @(negedge i_clk);
        i_vblank = 1'b0;
        @(negedge i_clk);
        chk("midrst_cx", 32'(o_cx), 320);
        chk("midrst_band", 32'(o_band), 100);
        chk("midrst_upd", 32'(o_upd), 0);
        chk("midrst_cnt", 32'(o_frame_cnt), 0);
        chk("midrst_ready", 32'(bus.wr_ready), 1);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        do_frame(4);

        repeat (3) @(negedge i_clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
